// File: rtl/matriz_led_pwm_if.sv
// ----------------------------------------------------------------------------
// matriz_led_pwm_if
// Frame-load handshake between a frame producer and the LED matrix driver.
//
//   pix_in      producer -> driver  ROWS*COLS bits, row r in [r*COLS +: COLS]
//   bright_in   producer -> driver  on-time per row slot, in clocks
//   load_valid  producer -> driver  pix_in/bright_in are offered
//   load_ready  driver -> producer  shadow buffer is free
//
// A transfer happens on a rising clock edge where load_valid and load_ready
// are both high.
// ----------------------------------------------------------------------------
interface matriz_led_pwm_if #(
    parameter int ROWS      = 4,
    parameter int COLS      = 8,
    parameter int SLOT_BITS = 10
);
    logic [ROWS*COLS-1:0] pix_in;
    logic [SLOT_BITS-1:0] bright_in;
    logic                 load_valid;
    logic                 load_ready;

    modport master (
        output pix_in,
        output bright_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  pix_in,
        input  bright_in,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/matriz_led_pwm.sv
// ----------------------------------------------------------------------------
// matriz_led_pwm
// Row-multiplexed LED matrix driver with per-slot PWM brightness and a
// double-buffered frame (shadow buffer loaded by handshake, copied to the
// active buffer only at the frame boundary).
//
//   clk12Mhz     in   single clock, rising edge
//   rst          in   synchronous active-low reset
//   load_if      slave modport: pix_in, bright_in, load_valid -> load_ready
//   blank        in   force all LEDs off, scan keeps running
//   leds         out  COLS bits, active-low column drive
//   lcol         out  ROWS bits, active-low row select (one-cold or all ones)
//   frame_start  out  one-clock pulse on the first output cycle of row 0
//
// Each row owns a slot of 2^SLOT_BITS clocks. The first DEAD clocks of every
// slot are blanked so the previous row is fully off before the next one is
// selected; the row is then lit for min(bright, 2^SLOT_BITS-DEAD) clocks.
// Outputs are registered, one clock behind the (row, cnt) scan state.
// ----------------------------------------------------------------------------
module matriz_led_pwm #(
    parameter int ROWS      = 4,
    parameter int COLS      = 8,
    parameter int SLOT_BITS = 10,
    parameter int DEAD      = 16
) (
    input  logic                  clk12Mhz,
    input  logic                  rst,
    matriz_led_pwm_if.slave       load_if,
    input  logic                  blank,
    output logic [COLS-1:0]       leds,
    output logic [ROWS-1:0]       lcol,
    output logic                  frame_start
);

    localparam int ROW_W = $clog2(ROWS);

    // One extra bit so the saturated on-time 2^SLOT_BITS (DEAD=0) fits.
    typedef logic [SLOT_BITS:0] ext_t;

    localparam ext_t                 ON_MAX   = ext_t'((2 ** SLOT_BITS) - DEAD);
    localparam ext_t                 DEAD_E   = ext_t'(DEAD);
    localparam logic [SLOT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(ROWS - 1);

    logic [SLOT_BITS-1:0] cnt_q,        cnt_d;
    logic [ROW_W-1:0]     row_q,        row_d;
    logic [ROWS*COLS-1:0] act_pix_q,    act_pix_d;
    logic [SLOT_BITS-1:0] act_bright_q, act_bright_d;
    logic [ROWS*COLS-1:0] shd_pix_q,    shd_pix_d;
    logic [SLOT_BITS-1:0] shd_bright_q, shd_bright_d;
    logic                 pending_q,    pending_d;
    logic [COLS-1:0]      leds_q,       leds_d;
    logic [ROWS-1:0]      lcol_q,       lcol_d;
    logic                 fstart_q,     fstart_d;

    logic                 slot_end;
    logic                 boundary;
    logic                 lit;
    ext_t                 bright_act;
    ext_t                 on_time;
    logic [COLS-1:0]      row_data;

    // The shadow buffer is free exactly when no frame is waiting for the
    // boundary; reset clears pending, so this reads 1 during reset.
    assign load_if.load_ready = ~pending_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        cnt_d        = cnt_q + 1'b1;
        row_d        = row_q;
        act_pix_d    = act_pix_q;
        act_bright_d = act_bright_q;
        shd_pix_d    = shd_pix_q;
        shd_bright_d = shd_bright_q;
        pending_d    = pending_q;
        row_data     = '0;

        slot_end = (cnt_q == CNT_MAX);
        boundary = slot_end && (row_q == ROW_LAST);

        // Row index wraps explicitly so non-power-of-2 ROWS work.
        if (slot_end) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end

        // Shadow is only written while free, and only promoted at the
        // boundary, so a capture on the boundary clock waits a full frame.
        if (pending_q) begin
            if (boundary) begin
                act_pix_d    = shd_pix_q;
                act_bright_d = shd_bright_q;
                pending_d    = 1'b0;
            end
        end else if (load_if.load_valid) begin
            shd_pix_d    = load_if.pix_in;
            shd_bright_d = load_if.bright_in;
            pending_d    = 1'b1;
        end

        for (int i = 0; i < ROWS; i++) begin
            if (row_q == ROW_W'(i)) begin
                row_data = act_pix_q[i*COLS +: COLS];
            end
        end

        bright_act = (ext_t'(act_bright_q) > ON_MAX) ? ON_MAX : ext_t'(act_bright_q);
        on_time    = ext_t'(cnt_q) - DEAD_E;
        lit        = (ext_t'(cnt_q) >= DEAD_E) && (on_time < bright_act) && !blank;

        leds_d   = lit ? ~row_data : '1;
        lcol_d   = lit ? ~(ROWS'(1) << row_q) : '1;
        fstart_d = (cnt_q == '0) && (row_q == '0);
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset
    // also clears both frame buffers, because a lit pixel from stale data
    // must never reach the matrix after reset.
    always_ff @(posedge clk12Mhz) begin
        if (!rst) begin
            cnt_q        <= '0;
            row_q        <= '0;
            act_pix_q    <= '0;
            act_bright_q <= '0;
            shd_pix_q    <= '0;
            shd_bright_q <= '0;
            pending_q    <= 1'b0;
            leds_q       <= '1;
            lcol_q       <= '1;
            fstart_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            act_pix_q    <= act_pix_d;
            act_bright_q <= act_bright_d;
            shd_pix_q    <= shd_pix_d;
            shd_bright_q <= shd_bright_d;
            pending_q    <= pending_d;
            leds_q       <= leds_d;
            lcol_q       <= lcol_d;
            fstart_q     <= fstart_d;
        end
    end

    assign leds        = leds_q;
    assign lcol        = lcol_q;
    assign frame_start = fstart_q;

endmodule

// File: tb/tb_matriz_led_pwm.sv
// ----------------------------------------------------------------------------
// tb_matriz_led_pwm
// Self-checking bench for matriz_led_pwm with ROWS=4, COLS=8, SLOT_BITS=6,
// DEAD=4 (64-clock slots, 256-clock frames). Output cycle k counts clocks
// from the frame_start cycle (k=0): row r = k/64, cnt = k%64.
// ----------------------------------------------------------------------------
module tb_matriz_led_pwm;

    localparam int ROWS      = 4;
    localparam int COLS      = 8;
    localparam int SLOT_BITS = 6;
    localparam int DEAD      = 4;

    // Rows: row0=A5, row1=3C, row2=FF, row3=01.
    localparam logic [31:0] PIX = 32'h01FF_3CA5;

    logic            clk;
    logic            rst;
    logic            blank;
    logic [COLS-1:0] leds;
    logic [ROWS-1:0] lcol;
    logic            frame_start;

    int checks = 0;
    int errors = 0;

    matriz_led_pwm_if #(.ROWS(ROWS), .COLS(COLS), .SLOT_BITS(SLOT_BITS)) bus ();

    matriz_led_pwm #(
        .ROWS(ROWS), .COLS(COLS), .SLOT_BITS(SLOT_BITS), .DEAD(DEAD)
    ) dut (
        .clk12Mhz    (clk),
        .rst         (rst),
        .load_if     (bus.slave),
        .blank       (blank),
        .leds        (leds),
        .lcol        (lcol),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pix;
        logic [5:0]  bright;
        logic        blank;
        int          k;
        logic [3:0]  lcol;
        logic [7:0]  leds;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge where frame_start is seen (output cycle k=0).
    task automatic wait_fs(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    // Offer one word for one clock, called at a negedge; inputs are scrambled
    // afterwards since they need not stay stable.
    task automatic load(input logic [31:0] pix, input logic [5:0] br);
        bus.pix_in     = pix;
        bus.bright_in  = br;
        bus.load_valid = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.pix_in     = 32'hDEAD_BEEF;
        bus.bright_in  = 6'd33;
    endtask

    // At most one row may ever be selected.
    always @(negedge clk) begin
        if (rst === 1'b1 && $countones(~lcol) > 1) begin
            errors++;
            $display("FAIL lcol_one_cold: got %b, expected at most one low bit", lcol);
        end
    end

    initial begin
        logic found;
        int   n;

        vecs[0]  = '{PIX, 6'd10, 1'b0,   0, 4'hF, 8'hFF};
        vecs[1]  = '{PIX, 6'd10, 1'b0,   3, 4'hF, 8'hFF};
        vecs[2]  = '{PIX, 6'd10, 1'b0,   4, 4'hE, 8'h5A};
        vecs[3]  = '{PIX, 6'd10, 1'b0,  13, 4'hE, 8'h5A};
        vecs[4]  = '{PIX, 6'd10, 1'b0,  14, 4'hF, 8'hFF};
        vecs[5]  = '{PIX, 6'd10, 1'b0,  63, 4'hF, 8'hFF};
        vecs[6]  = '{PIX, 6'd10, 1'b0,  68, 4'hD, 8'hC3};
        vecs[7]  = '{PIX, 6'd10, 1'b0, 136, 4'hB, 8'h00};
        vecs[8]  = '{PIX, 6'd10, 1'b0, 205, 4'h7, 8'hFE};
        vecs[9]  = '{PIX, 6'd63, 1'b0,  63, 4'hE, 8'h5A};
        vecs[10] = '{PIX, 6'd63, 1'b0,  67, 4'hF, 8'hFF};
        vecs[11] = '{PIX, 6'd63, 1'b0,  68, 4'hD, 8'hC3};
        vecs[12] = '{PIX, 6'd0,  1'b0,   4, 4'hF, 8'hFF};
        vecs[13] = '{PIX, 6'd0,  1'b0, 100, 4'hF, 8'hFF};
        vecs[14] = '{PIX, 6'd10, 1'b1,   4, 4'hF, 8'hFF};
        vecs[15] = '{PIX, 6'd60, 1'b0,  63, 4'hE, 8'h5A};
        vecs[16] = '{PIX, 6'd1,  1'b0,   4, 4'hE, 8'h5A};
        vecs[17] = '{PIX, 6'd1,  1'b0,   5, 4'hF, 8'hFF};

        rst            = 1'b0;
        blank          = 1'b0;
        bus.load_valid = 1'b0;
        bus.pix_in     = '0;
        bus.bright_in  = '0;

        // Reset state and first frame_start one clock after release.
        step(3);
        check("rst_leds",   32'(leds), 32'hFF);
        check("rst_lcol",   32'(lcol), 32'hF);
        check("rst_fs",     32'(frame_start), 32'd0);
        check("rst_ready",  32'(bus.load_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("first_fs",      32'(frame_start), 32'd1);
        check("first_fs_lcol", 32'(lcol), 32'hF);
        @(negedge clk);
        check("first_fs_pulse", 32'(frame_start), 32'd0);

        // Table: load, wait for the frame that shows it, sample cycle k.
        foreach (vecs[i]) begin
            wait_fs($sformatf("vec%0d_fs_a", i));
            load(vecs[i].pix, vecs[i].bright);
            blank = vecs[i].blank;
            wait_fs($sformatf("vec%0d_fs_b", i));
            step(vecs[i].k);
            check($sformatf("vec%0d_lcol", i), 32'(lcol), 32'(vecs[i].lcol));
            check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].leds));
            blank = 1'b0;
        end

        // Second offer while pending is ignored; ready returns after boundary.
        wait_fs("pend_fs");
        load(32'h0000_0081, 6'd10);
        check("pend_ready_low", 32'(bus.load_ready), 32'd0);
        bus.pix_in     = 32'h0000_0000;
        bus.bright_in  = 6'd10;
        bus.load_valid = 1'b1;
        step(5);
        check("pend_still_low", 32'(bus.load_ready), 32'd0);
        bus.load_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.load_ready) begin
                found = 1'b1;
                break;
            end
        end
        check("pend_ready_back", 32'(found), 32'd1);
        check("pend_ready_before_fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        check("pend_fs_after_ready", 32'(frame_start), 32'd1);
        step(4);
        check("pend_first_kept_leds", 32'(leds), 32'h7E);
        check("pend_first_kept_lcol", 32'(lcol), 32'hE);

        // Capture on the boundary clock itself: old frame shown once more.
        wait_fs("bnd_fs_a");
        step(254);
        load(32'h0000_003C, 6'd10);
        check("bnd_captured", 32'(bus.load_ready), 32'd0);
        @(negedge clk);
        check("bnd_fs", 32'(frame_start), 32'd1);
        step(4);
        check("bnd_old_frame", 32'(leds), 32'h7E);
        wait_fs("bnd_fs_b");
        step(4);
        check("bnd_new_frame", 32'(leds), 32'hC3);

        // Blank mid-slot takes effect one clock later; frame period unchanged.
        load(PIX, 6'd63);
        wait_fs("blank_fs_a");
        step(10);
        check("blank_pre_lcol", 32'(lcol), 32'hE);
        check("blank_pre_leds", 32'(leds), 32'h5A);
        blank = 1'b1;
        @(negedge clk);
        check("blank_1clk_lcol", 32'(lcol), 32'hF);
        check("blank_1clk_leds", 32'(leds), 32'hFF);
        wait_fs("blank_fs_b");
        n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n++;
            if (frame_start) break;
        end
        check("blank_fs_period", 32'(n), 32'd256);
        blank = 1'b0;

        // Reset mid-row with a pending load: everything discarded.
        wait_fs("rstm_fs_a");
        step(70);
        load(32'hFFFF_FFFF, 6'd20);
        step(5);
        check("rstm_pending", 32'(bus.load_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstm_leds",  32'(leds), 32'hFF);
        check("rstm_lcol",  32'(lcol), 32'hF);
        check("rstm_ready", 32'(bus.load_ready), 32'd1);
        check("rstm_fs",    32'(frame_start), 32'd0);
        step(2);
        rst = 1'b1;
        @(negedge clk);
        check("rstm_fs_after", 32'(frame_start), 32'd1);
        step(4);
        check("rstm_dark", 32'(lcol), 32'hF);
        wait_fs("rstm_fs_b");
        step(4);
        check("rstm_lost_lcol", 32'(lcol), 32'hF);
        check("rstm_lost_leds", 32'(leds), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matriz_led_pwm.md
MATRIZ_LED_PWM -- requirements
Module: matriz_led_pwm

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of multiplexed rows (lcol lines); legal range 2..16.
REQ-002 SHALL have parameter COLS, default 8: LEDs per row (leds lines); legal range 1..32.
REQ-003 SHALL have parameter SLOT_BITS, default 10: each row slot lasts 2^SLOT_BITS clocks.
REQ-004 SHALL have parameter DEAD, default 16: blanking clocks at the start of each slot (anti-ghosting); legal range 0 <= DEAD < 2^SLOT_BITS.
REQ-005 SHALL have port clk12Mhz, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port pix_in, input, ROWS*COLS bits: new frame; bits [r*COLS +: COLS] are row r, 1 = LED lit.
REQ-008 SHALL have port bright_in, input, SLOT_BITS bits: new on-time per slot, in clocks.
REQ-009 SHALL have port load_valid, input, 1 bit: pix_in/bright_in offered.
REQ-010 SHALL have port load_ready, output, 1 bit: shadow buffer free.
REQ-011 SHALL have port blank, input, 1 bit: force all LEDs off while 1; the scan keeps running.
REQ-012 SHALL have port leds, output, COLS bits: active-low column drive.
REQ-013 SHALL have port lcol, output, ROWS bits: active-low row select, one-cold or all-ones.
REQ-014 SHALL have port frame_start, output, 1 bit: one-clock pulse at the first output cycle of row 0.

Function
REQ-015 SHALL run a slot counter cnt, 0..2^SLOT_BITS-1, that wraps and advances row index r, 0..ROWS-1; r wraps to 0 after ROWS-1 (non-power-of-2 ROWS legal).
REQ-016 SHALL compute on = (cnt >= DEAD) and (cnt - DEAD < bright_act) and not blank, where bright_act = active brightness saturated to 2^SLOT_BITS - DEAD.
REQ-017 SHALL register outputs with 1-clock latency from (r, cnt): when on, lcol = all ones except bit r = 0, leds = ~active row r data; otherwise lcol = all ones and leds = all ones.
REQ-018 SHALL never drive more than one lcol bit low, and SHALL hold all lcol bits high for at least DEAD clocks between different rows.
REQ-019 SHALL assert frame_start for exactly one clock, aligned with the output cycle of (r=0, cnt=0); the period is ROWS*2^SLOT_BITS clocks, independent of blank and brightness.
REQ-020 SHALL capture pix_in/bright_in into the shadow buffer, set pending and drop load_ready on the next clock when load_valid and load_ready are both 1.
REQ-021 SHALL, on the frame-boundary clock (r=ROWS-1, cnt=max) with pending=1, copy shadow to active, clear pending and raise load_ready on the next clock; the first new-frame output is that frame's frame_start cycle.
REQ-022 SHALL ignore load_valid while load_ready=0; pix_in/bright_in need not be stable afterwards.
REQ-023 SHALL, when a capture happens on the frame-boundary clock with pending=0, apply the new data at the following boundary, not the current one.
REQ-024 SHALL never light a row when bright_act=0, and SHALL never change the active buffer mid-frame.

Reset
REQ-025 SHALL, while rst=0 at a clock edge, set cnt=0, r=0, active pixels=0, active bright=0, shadow=0, pending=0.
REQ-026 SHALL hold load_ready=1, leds=all ones, lcol=all ones and frame_start=0 during reset; reset mid-frame or mid-handshake discards all state.
REQ-027 SHALL emit the first frame_start 1 clock after the first edge with rst=1 (counter state 0 appears at the outputs).

Verification (ROWS=4, COLS=8, SLOT_BITS=6, DEAD=4)
REQ-028 SHALL verify: load pix_in row0=0xA5, bright_in=10 -> from the next frame_start, lcol=1110 and leds=0x5A during slot cycles 4..13, all ones on cycles 0..3 and 14..63.
REQ-029 SHALL verify: bright_in=63 -> on-time saturates to 60 clocks per slot; bright_in=0 -> lcol stays 1111 for the whole frame.
REQ-030 SHALL verify: second load_valid while pending -> load_ready=0 and the input is ignored; load_ready returns to 1 one clock after the boundary.
REQ-031 SHALL verify: capture on the boundary clock -> the old frame is shown for one more full frame (256 clocks), then the new one.
REQ-032 SHALL verify: blank=1 mid-slot -> leds/lcol go all ones 1 clock later; frame_start keeps a 256-clock period.
REQ-033 SHALL verify: rst=0 mid-row with a pending load -> outputs all ones, load_ready=1, the pending data is lost, and frame_start arrives 1 clock after rst returns to 1.
